// File: rtl/ws_frame_buffer.sv
// Double-buffered 24-bit pixel store feeding the WS2812 driver; banks swap only at a frame start.
// Optional build macro WS_FB_BRIGHTNESS_EN enables global brightness scaling in the output stage.
module ws_frame_buffer #(
  parameter int LEDS_NUM = 3,
  localparam int LED_ADDR_WIDTH = $clog2(LEDS_NUM + 1)
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      wr_valid,
  output logic                      wr_ready,
  input  logic [LED_ADDR_WIDTH-1:0] wr_addr,
  input  logic [23:0]               wr_data,
  input  logic                      commit,
  output logic                      swap_pending,
  output logic                      swap_done,
  input  logic [7:0]                brightness,
  input  logic                      new_data_req,
  input  logic [LED_ADDR_WIDTH-1:0] current_ledN,
  output logic [31:0]               color_rgb,
  output logic [1:0]                rd_state
);

  // Handshake: a write transfers on a rising clock edge where wr_valid && wr_ready;
  // wr_ready drops while a swap is pending so the back bank stays frozen until the swap.
  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA, R_OUT} rd_state_t;

  localparam logic [LED_ADDR_WIDTH-1:0] PIX_LIMIT = LED_ADDR_WIDTH'(LEDS_NUM);

  logic [23:0] bank0 [LEDS_NUM] = '{default: '0};
  logic [23:0] bank1 [LEDS_NUM] = '{default: '0};

  rd_state_t                 state;
  logic                      req_d;
  logic                      front_sel;
  logic [LED_ADDR_WIDTH-1:0] rd_idx;
  logic [23:0]               rd_word;
  logic [23:0]               front_word;
  logic [23:0]               out_word;

  assign wr_ready = !swap_pending;
  assign rd_state = state;

  // Host writes always target the bank the driver is not reading.
  always_ff @(posedge clock) begin
    if (wr_valid && wr_ready && (wr_addr < PIX_LIMIT)) begin
      if (front_sel) bank0[wr_addr] <= wr_data;
      else           bank1[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    front_word = '0;
    if (rd_idx < PIX_LIMIT) front_word = front_sel ? bank1[rd_idx] : bank0[rd_idx];
  end

`ifdef WS_FB_BRIGHTNESS_EN
  function automatic logic [7:0] scale8(input logic [7:0] c, input logic [7:0] b);
    logic [15:0] prod;
    prod = {8'h00, c} * ({8'h00, b} + 16'd1);
    return prod[15:8];
  endfunction

  always_comb begin
    out_word = {scale8(rd_word[23:16], brightness),
                scale8(rd_word[15:8], brightness),
                scale8(rd_word[7:0], brightness)};
  end
`else
  logic unused_brightness;
  assign unused_brightness = ^brightness;

  always_comb begin
    out_word = rd_word;
  end
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state        <= R_IDLE;
      req_d        <= 1'b0;
      front_sel    <= 1'b0;
      swap_pending <= 1'b0;
      swap_done    <= 1'b0;
      rd_idx       <= '0;
      rd_word      <= '0;
      color_rgb    <= '0;
    end else begin
      req_d     <= new_data_req;
      swap_done <= 1'b0;
      if (commit && !swap_pending) swap_pending <= 1'b1;
      case (state)
        R_IDLE: begin
          if (new_data_req && !req_d) begin
            state <= R_ADDR;
            // Swapping on the index-0 request edge means this read already sees the new frame.
            if ((current_ledN == '0) && swap_pending) begin
              front_sel    <= !front_sel;
              swap_pending <= 1'b0;
              swap_done    <= 1'b1;
            end
          end
        end
        R_ADDR: begin
          rd_idx <= current_ledN;
          state  <= R_DATA;
        end
        R_DATA: begin
          rd_word <= front_word;
          state   <= R_OUT;
        end
        R_OUT: begin
          color_rgb <= {8'h00, out_word};
          state     <= R_IDLE;
        end
        default: state <= R_IDLE;
      endcase
    end
  end

endmodule

// File: doc/ws_frame_buffer.md
# ws_frame_buffer

Double-buffered pixel store directly upstream of the WS2812 serial driver. A host writes 24-bit colours into a back bank while the driver reads the front bank through its `new_data_req` / `current_ledN` request interface. Banks swap only at a frame boundary, so the LED string never shows a half-updated frame.

## Interface
Parameters:
- `LEDS_NUM`, 3: number of pixels per frame; must equal the driver's `LEDS_NUM`.
- `LED_ADDR_WIDTH`, `$clog2(LEDS_NUM+1)`: width of pixel address ports (localparam); covers index `LEDS_NUM`.

Ports:
- `clock`  in  1  single system clock; all logic on its rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `wr_valid`  in  1  host write request.
- `wr_ready`  out  1  back bank accepts writes.
- `wr_addr`  in  LED_ADDR_WIDTH  pixel index to write.
- `wr_data`  in  24  colour, [7:0] R, [15:8] G, [23:16] B.
- `commit`  in  1  one-cycle pulse: back frame complete, request swap.
- `swap_pending`  out  1  commit accepted, swap not yet done.
- `swap_done`  out  1  one-cycle pulse when banks swap.
- `brightness`  in  8  global scale factor (used only with `WS_FB_BRIGHTNESS_EN`).
- `new_data_req`  in  1  from driver: pixel request level.
- `current_ledN`  in  LED_ADDR_WIDTH  from driver: requested pixel index.
- `color_rgb`  out  32  to driver: [23:0] colour, [31:24] always 0.

## Operation
- Two banks of `LEDS_NUM` x 24-bit RAM. `front_sel` selects the bank the driver reads; the host writes the other bank.
- Memory power-up contents are zero. Reset does not clear memory.
- Write: a write is accepted when `wr_valid & wr_ready`. `wr_data` is stored at `wr_addr` in the back bank. Writes with `wr_addr >= LEDS_NUM` are accepted and discarded.
- `wr_ready = !swap_pending`.
- Commit handling:
  - `commit` while `swap_pending` is 0 sets it.
  - `commit` while `swap_pending` is 1 is ignored.
  - A write and a commit in the same cycle: the write lands before the swap.
- Read FSM states: `R_IDLE`, `R_ADDR`, `R_DATA`, `R_OUT`.
  - `R_IDLE`: wait for a rising edge of `new_data_req` (registered `req_d`), then go to `R_ADDR`.
    - On that edge, if `current_ledN == 0` and `swap_pending`, toggle `front_sel`, clear `swap_pending`, and pulse `swap_done`.
    - This read already uses the new front bank.
  - `R_ADDR`: capture `current_ledN`; drive the front-bank RAM address. Go to `R_DATA`.
  - `R_DATA`: RAM output registered. If the index is `>= LEDS_NUM`, the value is forced to 0. Go to `R_OUT`.
  - `R_OUT`: optional scaling, then register into `color_rgb`. Go to `R_IDLE`.
- The driver sends indices `0..LEDS_NUM` inclusive. Index `LEDS_NUM` returns `0x00000000` (black pixel).
- After a swap the back bank holds the previous frame. No copy is made; the host rewrites every pixel it wants changed.
- Further `new_data_req` edges arriving while not in `R_IDLE` are ignored.

## Timing
- Reset values: `color_rgb = 0`, `wr_ready = 1`, `swap_pending = 0`, `swap_done = 0`, `front_sel = 0`, FSM in `R_IDLE`.
- Read latency: `new_data_req` is sampled high (previously low) at edge N; `color_rgb` is valid from edge N+3 and held until the next read.
  - The driver's `PREPARE_LATCH_DELAY` must be at least 4. The default of 10 is compliant.
- `swap_done` is high for exactly the one cycle after the swapping edge. `wr_ready` rises in that same cycle.
- Write latency: a value written at edge N is readable, after a swap, from edge N+1.
- Reset asserted mid-read or mid-swap:
  - All registers return to reset values immediately.
  - A pending swap is lost.
  - Memory is retained.

## Configuration
- `WS_FB_BRIGHTNESS_EN` defined: in `R_OUT`, each channel becomes `(c * (brightness + 1)) >> 8`, computed per byte with a 16-bit product. `brightness = 255` is identity; `brightness = 0` gives `c >> 8` = 0.
- Not defined: `R_OUT` is a plain register stage and `brightness` is ignored.
- Latency is 3 cycles in both builds.

## Test plan
- Write pixels 0..2 = `0x0000FF`, `0x00FF00`, `0xFF0000`; commit; driver requests 0,1,2,3 -> `swap_done` pulses on the index-0 request; `color_rgb` = `0x000000FF`, `0x0000FF00`, `0x00FF0000`, `0x00000000`.
- Commit mid-frame (during the index-1 request) -> index 1 and 2 still come from the old bank; the swap occurs at the next index-0 request; `wr_ready` stays 0 until then.
- Second `commit` while pending, plus `wr_valid` while pending -> no extra `swap_done`; write not accepted; back-bank contents unchanged.
- Write to `wr_addr = 3` with `LEDS_NUM = 3` -> accepted, no RAM change; index 3 still reads 0.
- With `WS_FB_BRIGHTNESS_EN`, `brightness = 127`, pixel `0x80FF40` -> `color_rgb = 0x00407F20`. Without the macro -> `0x0080FF40`.
- Assert `reset_n` low one cycle after a request edge with a swap pending -> outputs at reset values next edge; `swap_pending = 0`; the following frame shows the old front bank (bank 0).
